// File: rtl/req_pool8.sv
// req_pool8: per-client pending-job pool that drives an 8-way grant selector's req vector.
// Optional macro REQ_POOL_AGING_EN presents only starved clients while any client is starved.
module req_pool8 #(
    parameter int CNT_W        = 3,
    parameter int STARVE_LIMIT = 15
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [7:0] push,
    input  logic [7:0] gnt,
    output logic [7:0] req,
    output logic [7:0] done,
    output logic       pending_any,
    output logic [7:0] overflow,
    output logic [7:0] starve,
    output logic       grant_err
);

    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [7:0]       WAIT_LIM = 8'(STARVE_LIMIT);

    logic [CNT_W-1:0] r_cnt  [8];
    logic [7:0]       r_wait [8];
    logic [7:0]       r_done;
    logic [7:0]       r_overflow;
    logic             r_grant_err;

    logic [7:0] w_raw;
    logic [7:0] w_starve;
    logic [7:0] w_req;
    logic [7:0] w_vld;

    function automatic logic multi_hot(input logic [7:0] v);
        return (v & (v - 8'd1)) != 8'd0;
    endfunction

    function automatic logic [7:0] wait_sat_inc(input logic [7:0] w);
        return (w >= WAIT_LIM) ? WAIT_LIM : w + 8'd1;
    endfunction

    always_comb begin
        w_raw    = '0;
        w_starve = '0;
        for (int i = 0; i < 8; i++) begin
            w_raw[i]    = (r_cnt[i] != '0);
            w_starve[i] = (r_wait[i] == WAIT_LIM);
        end
    end

    // req depends on registered state only, so no gnt->req combinational loop exists
`ifdef REQ_POOL_AGING_EN
    assign w_req = (|w_starve) ? (w_raw & w_starve) : w_raw;
`else
    assign w_req = w_raw;
`endif

    assign w_vld = gnt & w_req;

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < 8; i++) begin
                r_cnt[i]  <= '0;
                r_wait[i] <= '0;
            end
            r_done      <= '0;
            r_overflow  <= '0;
            r_grant_err <= 1'b0;
        end else begin
            for (int i = 0; i < 8; i++) begin
                // push together with a valid grant leaves the count untouched
                case ({push[i], w_vld[i]})
                    2'b01:   r_cnt[i] <= r_cnt[i] - CNT_ONE;
                    2'b10: begin
                        if (r_cnt[i] == CNT_MAX) r_overflow[i] <= 1'b1;
                        else                     r_cnt[i] <= r_cnt[i] + CNT_ONE;
                    end
                    default: r_cnt[i] <= r_cnt[i];
                endcase

                if (w_vld[i])      r_wait[i] <= '0;
                else if (w_req[i]) r_wait[i] <= wait_sat_inc(r_wait[i]);
                else               r_wait[i] <= '0;
            end
            r_done      <= w_vld;
            r_grant_err <= multi_hot(gnt) | (|(gnt & ~w_req));
        end
    end

    assign req         = w_req;
    assign done        = r_done;
    assign pending_any = |w_raw;
    assign overflow    = r_overflow;
    assign starve      = w_starve;
    assign grant_err   = r_grant_err;

endmodule

// File: tb/tb_req_pool8.sv
// Bench for req_pool8: directed scenarios plus randomized traffic against a job-count model.
module tb_req_pool8;

    localparam int CNT_W = 3;
    localparam int LIMIT = 15;
    localparam int MAXC  = (1 << CNT_W) - 1;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] push  = '0;
    logic [7:0] gnt   = '0;
    logic [7:0] req, done, overflow, starve;
    logic       pending_any, grant_err;

    req_pool8 #(.CNT_W(CNT_W), .STARVE_LIMIT(LIMIT)) dut (
        .clock(clock), .reset(reset), .push(push), .gnt(gnt),
        .req(req), .done(done), .pending_any(pending_any),
        .overflow(overflow), .starve(starve), .grant_err(grant_err)
    );

    always #5 clock = ~clock;

    int   total  = 0;
    int   passed = 0;

    // Model: jobs outstanding and cycles waited per client
    int   m_jobs [8];
    int   m_wait [8];
    bit   m_ovf  [8];
    logic [7:0] m_done = '0;
    bit   m_gerr = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    function automatic logic [7:0] m_starve();
        logic [7:0] s = '0;
        for (int i = 0; i < 8; i++) s[i] = (m_wait[i] == LIMIT);
        return s;
    endfunction

    function automatic logic [7:0] m_req();
        logic [7:0] r = '0;
        for (int i = 0; i < 8; i++) r[i] = (m_jobs[i] > 0);
`ifdef REQ_POOL_AGING_EN
        if (m_starve() != 0) r = r & m_starve();
`endif
        return r;
    endfunction

    function automatic logic [7:0] m_ovf_vec();
        logic [7:0] o = '0;
        for (int i = 0; i < 8; i++) o[i] = m_ovf[i];
        return o;
    endfunction

    // Fixed-priority selector: highest index wins
    function automatic logic [7:0] sel(input logic [7:0] r);
        for (int i = 7; i >= 0; i--) if (r[i]) return 8'(1 << i);
        return 8'h00;
    endfunction

    task automatic step(input logic [7:0] p, input logic [7:0] g, input bit rst);
        logic [7:0] r;
        int nbits;
        @(negedge clock);
        push  = p;
        gnt   = g;
        reset = rst;
        r = m_req();
        if (rst) begin
            for (int i = 0; i < 8; i++) begin
                m_jobs[i] = 0; m_wait[i] = 0; m_ovf[i] = 0;
            end
            m_done = '0;
            m_gerr = 0;
        end else begin
            nbits = $countones(g);
            m_gerr = (nbits > 1) || ((g & ~r) != 0);
            for (int i = 0; i < 8; i++) begin
                bit v;
                v = g[i] && r[i];
                if (v && !p[i]) m_jobs[i]--;
                else if (p[i] && !v) begin
                    if (m_jobs[i] < MAXC) m_jobs[i]++;
                    else m_ovf[i] = 1;
                end
                if (v)         m_wait[i] = 0;
                else if (r[i]) m_wait[i] = (m_wait[i] < LIMIT) ? m_wait[i] + 1 : LIMIT;
                else           m_wait[i] = 0;
                m_done[i] = v;
            end
        end
        @(posedge clock);
        #1;
        chk("req", req, m_req());
        chk("done", done, m_done);
        chk("pending_any", pending_any, (m_req() != 0 || m_starve() != 0) ? 1'b1 : 1'b0);
        chk("overflow", overflow, m_ovf_vec());
        chk("starve", starve, m_starve());
        chk("grant_err", grant_err, m_gerr);
    endtask

    initial begin
        for (int i = 0; i < 8; i++) begin
            m_jobs[i] = 0; m_wait[i] = 0; m_ovf[i] = 0;
        end

        // Reset state
        step(8'h00, 8'h00, 1);
        step(8'h00, 8'h00, 1);
        chk("rst_req", req, 8'h00);
        chk("rst_pending", pending_any, 1'b0);

        // Single job on client 3
        step(8'h08, 8'h00, 0);
        chk("push3_req", req, 8'h08);
        step(8'h00, 8'h08, 0);
        chk("gnt3_done", done, 8'h08);
        chk("gnt3_req", req, 8'h00);

        // Overflow on client 0, then drain
        for (int k = 0; k < 8; k++) step(8'h01, 8'h00, 0);
        chk("ovf0", overflow, 8'h01);
        for (int k = 0; k < 7; k++) begin
            step(8'h00, 8'h01, 0);
            chk("drain0_done", done, 8'h01);
        end
        chk("drain0_req", req[0], 1'b0);

        // Push and grant together on client 5 with two pending
        step(8'h00, 8'h00, 1);
        step(8'h20, 8'h00, 0);
        step(8'h20, 8'h00, 0);
        step(8'h20, 8'h20, 0);
        chk("pg5_done", done, 8'h20);
        chk("pg5_ovf", overflow, 8'h00);
        chk("pg5_jobs", 32'(m_jobs[5]), 32'd2);
        step(8'h00, 8'h20, 0);
        step(8'h00, 8'h20, 0);
        chk("pg5_drained", req[5], 1'b0);

        // Multi-hot grant with one unrequested bit
        step(8'h00, 8'h00, 1);
        step(8'h10, 8'h00, 0);
        step(8'h00, 8'h30, 0);
        chk("gerr", grant_err, 1'b1);
        chk("gerr_done", done, 8'h10);
        chk("gerr_req", req, 8'h00);
        step(8'h00, 8'h00, 0);
        chk("gerr_clear", grant_err, 1'b0);

        // Starvation: client 7 always served, client 0 waits
        step(8'h00, 8'h00, 1);
        step(8'h81, 8'h00, 0);
        for (int k = 0; k < 20; k++) step(8'h80, sel(m_req()), 0);
`ifndef REQ_POOL_AGING_EN
        chk("starve0", starve[0], 1'b1);
        chk("starve0_req", req, 8'h81);
`else
        chk("aging_served0", 32'(m_jobs[0]), 32'd0);
`endif

        // Reset with every client pending and a simultaneous push
        step(8'h00, 8'h00, 1);
        for (int k = 0; k < 3; k++) step(8'hFF, 8'h00, 0);
        step(8'hFF, 8'hFF, 1);
        chk("midrst_req", req, 8'h00);
        chk("midrst_pending", pending_any, 1'b0);
        chk("midrst_done", done, 8'h00);

        // Randomized traffic
        for (int k = 0; k < 400; k++) begin
            logic [7:0] p, g;
            p = 8'($urandom) & 8'($urandom);
            if ($urandom_range(0, 99) < 85) g = sel(m_req());
            else                            g = 8'($urandom);
            step(p, g, $urandom_range(0, 99) == 0);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/req_pool8.md
# req_pool8

Requester-side companion to the 8-way fixed-priority grant selector. It holds per-client pending-job counts and drives the selector's `req[7:0]`. It consumes the one-hot `gnt[7:0]` that comes back, retiring one job per grant. It also reports completions, overflow, starvation and grant-protocol errors. It sits between eight job sources and the combinational selector, and closes the req→gnt loop without a combinational path from `gnt` to `req`.

## Interface
Parameters:
- `CNT_W`, 3: width of each per-client pending counter. Maximum pending jobs per client = 2^CNT_W − 1.
- `STARVE_LIMIT`, 15: number of consecutive requested-but-ungranted cycles before a client is flagged starved. Legal range 1..255.

Ports:
- `clock`  in  1  sole clock; all state updates on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `push`  in  8  one-cycle pulse per client; adds one pending job.
- `gnt`  in  8  grant vector from the selector; expected one-hot or zero.
- `req`  out  8  request vector to the selector.
- `done`  out  8  registered; pulses one cycle after the corresponding job is granted.
- `pending_any`  out  1  high when any client's pending count is nonzero.
- `overflow`  out  8  sticky; set when a push arrives while that client's count is full.
- `starve`  out  8  set while a client's wait counter equals `STARVE_LIMIT`.
- `grant_err`  out  1  registered; pulses one cycle after an illegal `gnt`.

## Operation
- Per client i: a pending counter `cnt[i]` (CNT_W bits) and a wait counter `wait[i]` (8 bits, saturating at `STARVE_LIMIT`).
- Raw request: `raw[i] = (cnt[i] != 0)`. `req` is a function of registered state only, never of `gnt`.
- A grant is valid when `gnt[i] & req[i]`. Each cycle, per client:
  - Valid grant and no push: `cnt` decrements.
  - Push and no valid grant: `cnt` increments if `cnt` < max. If `cnt` = max, the push is dropped and `overflow[i]` is set.
  - Push and valid grant together: `cnt` is unchanged. No overflow is flagged even when full.
  - `done[i]` is set next cycle to the registered value of the valid grant.
- Wait counter:
  - Valid grant: clears to 0.
  - Else if `req[i]`: increments, saturating at `STARVE_LIMIT`.
  - Else (no request): clears to 0.
- `starve[i] = (wait[i] == STARVE_LIMIT)`.
- `grant_err` is set next cycle if `gnt` has more than one bit set, or if any `gnt[i]` is high while `req[i]` is low.
  - Illegal bits (granted without request) have no effect on `cnt`.
  - When `gnt` is multi-hot, each bit that matches a request is still honoured individually.
- `pending_any = |raw`. This output is not masked by aging.

## Timing
- Reset: all `cnt`, all `wait`, `done`, `overflow`, `starve` and `grant_err` clear to 0, so `req` = 0 and `pending_any` = 0. Reset dominates push and gnt in the same cycle. Reset mid-operation discards all pending jobs.
- Latency:
  - A push in cycle N shows `req[i]` = 1 in cycle N+1.
  - A grant in cycle N shows `done[i]` = 1 in cycle N+1.
  - When the last job is granted in cycle N, `req[i]` drops in cycle N+1.
- Back-to-back grants to one client retire one job per cycle. A client with k jobs and continuous grant drains in k cycles.
- `overflow` clears only on reset.

## Configuration
- `REQ_POOL_AGING_EN` defined: if any `starve` bit is set, `req = raw & starve`. Only starved clients are presented to the selector, so the fixed-priority selector serves them highest-index-first and starvation is bounded. If no bit is set, `req = raw`.
- Not defined: `req = raw` always. `starve` is a status output only.

## Test plan
- Reset, then push client 3 once → `req` = 8'h08 next cycle. Drive `gnt` = 8'h08 → `done` = 8'h08 one cycle later and `req` = 0.
- CNT_W=3: push client 0 eight times with no grant → `cnt` saturates at 7 and `overflow` = 8'h01. Grant 7 cycles → 7 `done` pulses, then `req[0]` = 0.
- Simultaneous push and grant on client 5 with `cnt`=2 → `cnt` stays 2, `done[5]` pulses, no overflow.
- `gnt` = 8'h30 while `req` = 8'h10 → `grant_err` pulses. Client 4 retires one job; client 5 is unchanged.
- Clients 7 and 0 both pending, selector always grants 7, STARVE_LIMIT=15:
  - Without macro: `starve[0]` rises after 15 cycles and stays high.
  - With `REQ_POOL_AGING_EN`: `req` becomes 8'h01 and client 0 is granted next cycle.
- Reset asserted while all clients hold pending jobs → all outputs 0 next cycle, and a push in the same cycle as reset is ignored.
